// File: rtl/dcache_store_drain_if.sv
// ---------------------------------------------------------------------------
// dcache_store_drain_if
//
// Purpose:
//   Groups every signal between the store-drain engine and its three
//   neighbours into one bundle:
//   - the store buffer (pop strobe and oldest entry),
//   - the data-cache write port (request, handshake and response),
//   - the memory fill path.
//   It also carries the fence handshake and the status outputs.
//
// Modports:
//   master - the drain engine. It drives pop, write, fill and status signals.
//   slave  - the surrounding system. It drives buffer, cache, memory and
//            fence inputs.
//
// Signal summary:
//   sb_has_entry, sb_oldest_addr/data/be  : buffer -> engine
//   sb_get_oldest                         : engine -> buffer (1-cycle pop)
//   dc_wr_valid/addr/data/be              : engine -> cache write port
//   dc_wr_ready, dc_rsp_valid, dc_rsp_hit : cache -> engine
//   mem_fill_req, mem_fill_addr           : engine -> memory
//   mem_fill_done                         : memory -> engine
//   drain_req                             : core -> engine (fence)
//   drain_done, busy, miss_count          : engine status
// ---------------------------------------------------------------------------
interface dcache_store_drain_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int CNT_W  = 16
);

  // Store buffer side
  logic              sb_has_entry;
  logic              sb_get_oldest;
  logic [ADDR_W-1:0] sb_oldest_addr;
  logic [DATA_W-1:0] sb_oldest_data;
  logic [BE_W-1:0]   sb_oldest_be;

  // Cache write port
  logic              dc_wr_valid;
  logic              dc_wr_ready;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [DATA_W-1:0] dc_wr_data;
  logic [BE_W-1:0]   dc_wr_be;
  logic              dc_rsp_valid;
  logic              dc_rsp_hit;

  // Line fill path
  logic              mem_fill_req;
  logic [ADDR_W-1:0] mem_fill_addr;
  logic              mem_fill_done;

  // Fence and status
  logic              drain_req;
  logic              drain_done;
  logic              busy;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    input  sb_has_entry, sb_oldest_addr, sb_oldest_data, sb_oldest_be,
    input  dc_wr_ready, dc_rsp_valid, dc_rsp_hit,
    input  mem_fill_done, drain_req,
    output sb_get_oldest,
    output dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_be,
    output mem_fill_req, mem_fill_addr,
    output drain_done, busy, miss_count
  );

  modport slave (
    output sb_has_entry, sb_oldest_addr, sb_oldest_data, sb_oldest_be,
    output dc_wr_ready, dc_rsp_valid, dc_rsp_hit,
    output mem_fill_done, drain_req,
    input  sb_get_oldest,
    input  dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_be,
    input  mem_fill_req, mem_fill_addr,
    input  drain_done, busy, miss_count
  );

endinterface

// File: rtl/dcache_store_drain.sv
// ---------------------------------------------------------------------------
// dcache_store_drain
//
// Purpose:
//   Drain engine between the data-cache store buffer and the cache write
//   port. It pops the oldest buffered store and issues it as a cache write.
//   On a miss it requests a line fill and then retries the same write. Only
//   one store is in flight at a time, so the next pop waits for a hit.
//
//   Stores normally leave the buffer only after it has been non-empty for
//   IDLE_WAIT idle cycles, which gives neighbouring stores a chance to
//   merge. A drain (fence) request skips that wait.
//
// Ports:
//   clock - system clock
//   reset - asynchronous, active-low reset
//   bus   - dcache_store_drain_if.master. Carries:
//             store buffer pop and oldest entry,
//             cache write request, handshake and response,
//             fill request, address and done,
//             drain_req/drain_done, busy and the saturating miss_count.
// ---------------------------------------------------------------------------
module dcache_store_drain #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int IDLE_WAIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  dcache_store_drain_if.master  bus
);

  // FSM encoding
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WRITE    = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_FILL     = 2'd3;

  localparam logic [3:0]        L_IDLE_WAIT = 4'(IDLE_WAIT);
  // Byte offset within a line; cleared to form the fill address
  localparam logic [ADDR_W-1:0] L_LINE_MASK = ADDR_W'(BE_W - 1);
  localparam logic [CNT_W-1:0]  L_CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [3:0]        r_idle_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [BE_W-1:0]   r_be;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic w_in_idle;
  logic w_pop;
  logic w_wr_fire;
  logic w_rsp_hit;
  logic w_rsp_miss;
  logic w_fill_done;

  assign w_in_idle = (r_state == S_IDLE);

  // The pop strobe is combinational so that the buffer's oldest entry can be
  // captured on the same edge. It is gated by reset so that no strobe
  // escapes while reset is held, even though the FSM already reads IDLE.
  assign w_pop = reset && w_in_idle && bus.sb_has_entry &&
                 (bus.drain_req || (r_idle_cnt == L_IDLE_WAIT));

  // Events are qualified by state. A response or fill-done seen in any
  // other state is stray and is ignored.
  assign w_wr_fire   = (r_state == S_WRITE) && bus.dc_wr_ready;
  assign w_rsp_hit   = (r_state == S_WAIT_RSP) && bus.dc_rsp_valid &&  bus.dc_rsp_hit;
  assign w_rsp_miss  = (r_state == S_WAIT_RSP) && bus.dc_rsp_valid && !bus.dc_rsp_hit;
  assign w_fill_done = (r_state == S_FILL) && bus.mem_fill_done;

  // Next-state logic. A miss loops back through FILL to WRITE, so the same
  // captured store is retried until the cache reports a hit.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_pop)       w_next_state = S_WRITE;
      S_WRITE:    if (w_wr_fire)   w_next_state = S_WAIT_RSP;
      S_WAIT_RSP: if (w_rsp_hit)   w_next_state = S_IDLE;
                  else if (w_rsp_miss) w_next_state = S_FILL;
      S_FILL:     if (w_fill_done) w_next_state = S_WRITE;
      default:                     w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Idle counter. It counts consecutive idle cycles with a non-empty buffer
  // and saturates at IDLE_WAIT. It restarts whenever the buffer empties or
  // an entry is popped. Outside IDLE it holds, and that value is always
  // zero because the pop cleared it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (w_in_idle) begin
      if (!bus.sb_has_entry || w_pop) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != L_IDLE_WAIT) begin
        r_idle_cnt <= r_idle_cnt + 4'd1;
      end
    end
  end

  // Capture the popped store. These registers then stay untouched until the
  // next pop, which keeps the write payload stable across back-pressure and
  // across fill retries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_be   <= '0;
    end else if (w_pop) begin
      r_addr <= bus.sb_oldest_addr;
      r_data <= bus.sb_oldest_data;
      r_be   <= bus.sb_oldest_be;
    end
  end

  // Saturating miss counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_miss_cnt <= '0;
    end else if (w_rsp_miss && (r_miss_cnt != L_CNT_MAX)) begin
      r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign bus.sb_get_oldest = w_pop;

  assign bus.dc_wr_valid   = (r_state == S_WRITE);
  assign bus.dc_wr_addr    = r_addr;
  assign bus.dc_wr_data    = r_data;
  assign bus.dc_wr_be      = r_be;

  assign bus.mem_fill_req  = (r_state == S_FILL);
  assign bus.mem_fill_addr = r_addr & ~L_LINE_MASK;

  // Like the pop strobe, the fence acknowledgement is reset-gated so that
  // every output reads zero while reset is held.
  assign bus.drain_done    = reset && bus.drain_req && w_in_idle && !bus.sb_has_entry;
  assign bus.busy          = !w_in_idle;
  assign bus.miss_count    = r_miss_cnt;

endmodule

// File: tb/tb_dcache_store_drain.sv
// ---------------------------------------------------------------------------
// tb_dcache_store_drain
//
// Purpose:
//   The bench plays three roles around the drain engine:
//   - a store buffer (a queue of stores),
//   - a cache that answers accepted writes with hits or misses,
//   - a memory that completes fills.
//   A transaction-level reference decides, every cycle, what the engine
//   must be doing: whether it pops, whether a write is outstanding, whether
//   a fill is pending, the fence status and the miss total.
// ---------------------------------------------------------------------------
module tb_dcache_store_drain;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int IDLE_WAIT = 4;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } store_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  dcache_store_drain_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .CNT_W(CNT_W)) bus ();

  dcache_store_drain #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
    .IDLE_WAIT(IDLE_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference state
  store_t           sbQ[$];
  store_t           cur;
  bit               inFlight, rspPending, rspHit, filling, forceMiss;
  int               rspAt, fillAt, waited, cyc;
  logic [CNT_W-1:0] expMiss;

  // Stimulus knobs
  int pushPct, readyPct, hitPct, strayPct, rspDelayMax, fillDelay;
  bit drainMode;

  // Observations of the DUT
  int                pushedCnt, obsPops, obsWrAccepts, validRun, maxValidRun;
  int                popCycles[$];
  logic [ADDR_W-1:0] wrAddrQ[$];
  logic [DATA_W-1:0] wrDataQ[$];
  logic [ADDR_W-1:0] obsFillAddr;
  bit                sawFill;

  // Counts one comparison and reports it if it fails
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic store_t randStore();
    store_t s;
    s.addr = $urandom;
    s.data = $urandom;
    s.be   = 4'($urandom_range(15, 1));
    return s;
  endfunction

  task automatic pushStore(input store_t s);
    sbQ.push_back(s);
    pushedCnt++;
  endtask

  task automatic resetModel();
    inFlight   = 1'b0;
    rspPending = 1'b0;
    filling    = 1'b0;
    forceMiss  = 1'b0;
    waited     = 0;
    expMiss    = '0;
  endtask

  // One clock cycle. The task drives the inputs just after the edge and
  // samples and checks the outputs 1 ns later. It then waits for the next
  // edge and advances the reference by the events of that cycle.
  task automatic applyStimulus();
    bit     has, rspFire, fillFire, expPop, expWrValid, accepted;
    store_t head;
    int     fd;

    has  = (sbQ.size() > 0);
    head = has ? sbQ[0] : '0;
    bus.sb_has_entry   = has;
    bus.sb_oldest_addr = head.addr;
    bus.sb_oldest_data = head.data;
    bus.sb_oldest_be   = head.be;
    bus.drain_req      = drainMode;
    bus.dc_wr_ready    = ($urandom_range(99) < readyPct);
    rspFire            = rspPending && (cyc >= rspAt);
    bus.dc_rsp_valid   = rspFire || (!rspPending && ($urandom_range(99) < strayPct));
    bus.dc_rsp_hit     = rspFire ? rspHit : 1'($urandom_range(1));
    fillFire           = filling && (cyc >= fillAt);
    bus.mem_fill_done  = fillFire || (!filling && ($urandom_range(99) < strayPct));
    #1;

    expPop     = !inFlight && has && (drainMode || waited == IDLE_WAIT);
    expWrValid = inFlight && !rspPending && !filling;
    checkOutput("pop",        bus.sb_get_oldest, expPop);
    checkOutput("busy",       bus.busy,          inFlight);
    checkOutput("wr_valid",   bus.dc_wr_valid,   expWrValid);
    checkOutput("fill_req",   bus.mem_fill_req,  filling);
    checkOutput("drain_done", bus.drain_done,    drainMode && !inFlight && !has);
    checkOutput("miss_count", bus.miss_count,    expMiss);
    if (expWrValid) begin
      checkOutput("wr_addr", bus.dc_wr_addr, cur.addr);
      checkOutput("wr_data", bus.dc_wr_data, cur.data);
      checkOutput("wr_be",   bus.dc_wr_be,   cur.be);
    end
    if (filling) begin
      checkOutput("fill_addr", bus.mem_fill_addr, cur.addr & ~32'h3);
      if (!sawFill) begin
        sawFill     = 1'b1;
        obsFillAddr = bus.mem_fill_addr;
      end
    end

    if (bus.sb_get_oldest) begin
      popCycles.push_back(cyc);
      obsPops++;
    end
    if (bus.dc_wr_valid && bus.dc_wr_ready) begin
      obsWrAccepts++;
      wrAddrQ.push_back(bus.dc_wr_addr);
      wrDataQ.push_back(bus.dc_wr_data);
      validRun = 0;
    end else if (bus.dc_wr_valid) begin
      validRun++;
      if (validRun > maxValidRun) maxValidRun = validRun;
    end
    accepted = expWrValid && bus.dc_wr_ready;

    @(posedge clock);
    #1;

    // Advance the reference with the events of the cycle just finished
    if (expPop) begin
      cur      = sbQ.pop_front();
      inFlight = 1'b1;
      waited   = 0;
    end else if (!inFlight) begin
      waited = has ? ((waited < IDLE_WAIT) ? waited + 1 : IDLE_WAIT) : 0;
    end
    if (accepted) begin
      rspPending = 1'b1;
      rspAt      = cyc + 1 + $urandom_range(rspDelayMax);
      rspHit     = forceMiss ? 1'b0 : ($urandom_range(99) < hitPct);
      forceMiss  = 1'b0;
    end
    if (rspFire) begin
      rspPending = 1'b0;
      if (rspHit) begin
        inFlight = 1'b0;
      end else begin
        filling = 1'b1;
        fd      = (fillDelay < 0) ? $urandom_range(5) : fillDelay;
        fillAt  = cyc + 1 + fd;
        if (expMiss != {CNT_W{1'b1}}) expMiss = expMiss + 1'b1;
      end
    end
    if (fillFire) filling = 1'b0;
    if (($urandom_range(99) < pushPct) && (sbQ.size() < 8)) pushStore(randStore());
    cyc++;
  endtask

  initial begin
    store_t s;
    int     c0;
    bit     done;

    pushPct = 0; readyPct = 100; hitPct = 100; strayPct = 0;
    rspDelayMax = 0; fillDelay = -1; drainMode = 1'b0;
    pushedCnt = 0; obsPops = 0; obsWrAccepts = 0; validRun = 0; maxValidRun = 0;
    sawFill = 1'b0; obsFillAddr = '0; cyc = 0;
    resetModel();
    bus.sb_has_entry = 1'b0; bus.sb_oldest_addr = '0; bus.sb_oldest_data = '0;
    bus.sb_oldest_be = '0; bus.dc_wr_ready = 1'b0; bus.dc_rsp_valid = 1'b0;
    bus.dc_rsp_hit = 1'b0; bus.mem_fill_done = 1'b0; bus.drain_req = 1'b0;

    // Outputs while reset is held
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_busy",     bus.busy,          1'b0);
    checkOutput("rst_wr_valid", bus.dc_wr_valid,   1'b0);
    checkOutput("rst_pop",      bus.sb_get_oldest, 1'b0);
    reset = 1'b1;

    // Test 1: empty buffer after reset, everything stays quiet
    repeat (10) applyStimulus();
    checkOutput("t1_wr_addr",   bus.dc_wr_addr,    0);
    checkOutput("t1_wr_data",   bus.dc_wr_data,    0);
    checkOutput("t1_wr_be",     bus.dc_wr_be,      0);
    checkOutput("t1_fill_addr", bus.mem_fill_addr, 0);

    // Test 2: single store, pop after IDLE_WAIT idle cycles, immediate hit
    s = '{addr: 32'h1000, data: 32'hDEADBEEF, be: 4'hF};
    pushStore(s);
    c0 = cyc;
    popCycles.delete();
    wrAddrQ.delete(); wrDataQ.delete();
    repeat (10) applyStimulus();
    checkOutput("t2_pop_count", popCycles.size(), 1);
    if (popCycles.size() > 0) checkOutput("t2_pop_delay", popCycles[0] - c0, IDLE_WAIT);
    if (wrAddrQ.size() > 0) begin
      checkOutput("t2_wr_addr", wrAddrQ[0], 32'h1000);
      checkOutput("t2_wr_data", wrDataQ[0], 32'hDEADBEEF);
    end
    checkOutput("t2_busy_end", bus.busy, 1'b0);

    // Test 3: drain of three entries, back-to-back pops 3 cycles apart
    drainMode = 1'b1;
    repeat (3) pushStore(randStore());
    c0 = cyc;
    popCycles.delete();
    repeat (12) applyStimulus();
    checkOutput("t3_pop_count", popCycles.size(), 3);
    if (popCycles.size() == 3) begin
      checkOutput("t3_first_pop", popCycles[0] - c0, 0);
      checkOutput("t3_spacing1",  popCycles[1] - popCycles[0], 3);
      checkOutput("t3_spacing2",  popCycles[2] - popCycles[1], 3);
    end
    checkOutput("t3_drain_done", bus.drain_done, 1'b1);
    drainMode = 1'b0;

    // Test 4: miss, fill after 5 cycles, then the identical write is retried
    forceMiss = 1'b1;
    fillDelay = 4;
    s = '{addr: 32'h2004, data: $urandom, be: 4'hF};
    pushStore(s);
    sawFill = 1'b0;
    wrAddrQ.delete(); wrDataQ.delete();
    repeat (20) applyStimulus();
    checkOutput("t4_saw_fill",   sawFill, 1'b1);
    checkOutput("t4_fill_addr",  obsFillAddr, 32'h2004);
    checkOutput("t4_miss_count", bus.miss_count, 1);
    checkOutput("t4_writes",     wrAddrQ.size(), 2);
    if (wrAddrQ.size() == 2) begin
      checkOutput("t4_retry_addr", wrAddrQ[1], 32'h2004);
      checkOutput("t4_retry_data", wrDataQ[1], s.data);
    end
    checkOutput("t4_busy_end", bus.busy, 1'b0);
    fillDelay = -1;

    // Test 5: back-pressure for 7 cycles with stray responses and fill-dones
    drainMode = 1'b1;
    readyPct = 0;
    strayPct = 100;
    maxValidRun = 0;
    validRun = 0;
    pushStore(randStore());
    repeat (8) applyStimulus();
    readyPct = 100;
    strayPct = 0;
    repeat (4) applyStimulus();
    checkOutput("t5_valid_hold", maxValidRun, 7);
    checkOutput("t5_miss_count", bus.miss_count, 1);
    checkOutput("t5_busy_end",   bus.busy, 1'b0);

    // Test 6: asynchronous reset while filling, then a fresh pop on release
    forceMiss = 1'b1;
    fillDelay = 50;
    repeat (3) pushStore(randStore());
    for (int i = 0; i < 20 && !filling; i++) applyStimulus();
    checkOutput("t6_reach_fill", filling, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_async_fill_req", bus.mem_fill_req,  1'b0);
    checkOutput("t6_async_busy",     bus.busy,          1'b0);
    checkOutput("t6_async_miss",     bus.miss_count,    0);
    checkOutput("t6_async_wr_addr",  bus.dc_wr_addr,    0);
    checkOutput("t6_async_pop",      bus.sb_get_oldest, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("t6_held_pop",        bus.sb_get_oldest, 1'b0);
    checkOutput("t6_held_drain_done", bus.drain_done,    1'b0);
    resetModel();
    fillDelay = -1;
    reset = 1'b1;
    popCycles.delete();
    applyStimulus();
    checkOutput("t6_fresh_pop", popCycles.size(), 1);
    repeat (10) applyStimulus();
    drainMode = 1'b0;

    // Randomized traffic
    pushPct = 30; readyPct = 70; hitPct = 75; strayPct = 5; rspDelayMax = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) drainMode = !drainMode;
      applyStimulus();
    end

    // Final fence: everything pushed must come out
    pushPct = 0;
    drainMode = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      applyStimulus();
      done = (sbQ.size() == 0) && !inFlight;
    end
    checkOutput("final_drained", done, 1'b1);
    checkOutput("final_pops", obsPops, pushedCnt);
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
